// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and defaults for the SNN spike front end.
//               syn_idx_t   - synapse index as written into the TOP_snn FIFO
//               inj_state_t - spike_index_injector FSM encoding
//               N_AXON_DEF  - default number of axons per timestep
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 8
`endif

package snn_pkg;

    localparam int N_AXON_DEF = 256;

    typedef logic [`SYNAPSE_INDEX-1:0] syn_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } inj_state_t;

endpackage : snn_pkg

`default_nettype wire

// File: rtl/lsb_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : lsb_prio_enc
// Description : Combinational lowest-set-bit priority encoder.
// Ports       : vec [N] in  - request vector
//               idx [W] out - index of the lowest set bit (0 when vec==0)
//               any     out - at least one bit of vec is set
// Revision    : 1.0 - initial release
// ============================================================================

module lsb_prio_enc #(
    parameter int N = 256,
    parameter int W = 8
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    assign any = |vec;

    // Scan from the top down so the last match (lowest bit) wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule : lsb_prio_enc

`default_nettype wire

// File: rtl/spike_index_injector.sv
`default_nettype none
// ============================================================================
// Module      : spike_index_injector
// Description : Converts one timestep's axon spike bitmap into a stream of
//               synapse indices (lowest first) written into the TOP_snn input
//               FIFO, one per clock, throttled by the FIFO flags.
// Ports       : clk, rstn           - clock, synchronous active-low reset
//               spk_valid/spk_ready - bitmap handshake
//               spk_map [N_AXON]    - spike bitmap, bit i => axon i fired
//               full, almost_full   - FIFO flags from TOP_snn
//               w_en, s_index_o     - registered FIFO write strobe / index
//               ts_done             - 1-cycle pulse, bitmap fully issued
//               ev_cnt [CNT_W]      - indices issued for current/last bitmap
// Revision    : 1.0 - initial release
// ============================================================================

module spike_index_injector
    import snn_pkg::*;
#(
    parameter int N_AXON = N_AXON_DEF,
    parameter int IDX_W  = `SYNAPSE_INDEX,
    parameter int CNT_W  = $clog2(N_AXON + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              spk_valid,
    output logic              spk_ready,
    input  logic [N_AXON-1:0] spk_map,
    input  logic              full,
    input  logic              almost_full,
    output logic              w_en,
    output logic [IDX_W-1:0]  s_index_o,
    output logic              ts_done,
    output logic [CNT_W-1:0]  ev_cnt
);

    localparam logic [N_AXON-1:0] c_pend_one = {{(N_AXON-1){1'b0}}, 1'b1};

    inj_state_t        r_state;
    logic [N_AXON-1:0] r_pend;
    logic              r_w_en;
    logic [IDX_W-1:0]  r_s_index;
    logic              r_ts_done;
    logic [CNT_W-1:0]  r_ev_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_can_issue;

    lsb_prio_enc #(
        .N (N_AXON),
        .W (IDX_W)
    ) u_lsb_prio_enc (
        .vec (r_pend),
        .idx (w_idx),
        .any (w_any)
    );

    // almost_full is the real throttle: because w_en is registered, one more
    // write can land after the flag rises, which the last free slot absorbs.
    assign w_can_issue = !almost_full && !full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_pend    <= '0;
            r_w_en    <= 1'b0;
            r_s_index <= '0;
            r_ts_done <= 1'b0;
            r_ev_cnt  <= '0;
        end else begin
            r_w_en    <= 1'b0;
            r_ts_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (spk_valid) begin
                        r_pend   <= spk_map;
                        r_ev_cnt <= '0;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_any) begin
                        // ts_done is high for exactly the single FIN cycle.
                        r_state   <= FIN;
                        r_ts_done <= 1'b1;
                    end else if (w_can_issue) begin
                        r_w_en    <= 1'b1;
                        r_s_index <= w_idx;
                        // x & (x-1) clears the lowest set bit, i.e. bit w_idx.
                        r_pend    <= r_pend & (r_pend - c_pend_one);
                        r_ev_cnt  <= r_ev_cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spk_ready = (r_state == IDLE);
    assign w_en      = r_w_en;
    assign s_index_o = r_s_index;
    assign ts_done   = r_ts_done;
    assign ev_cnt    = r_ev_cnt;

endmodule : spike_index_injector

`default_nettype wire

// File: tb/tb_spike_index_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_index_injector
// Description : Scoreboard bench for spike_index_injector. Stimulus pushes the
//               expected index stream and per-bitmap event count; a negedge
//               monitor pops and compares on every w_en / ts_done.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_spike_index_injector;

    localparam int N     = 256;
    localparam int IW    = 8;
    localparam int CW    = 9;
    localparam int DEPTH = 8;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          spk_valid = 1'b0;
    logic [N-1:0]  spk_map   = '0;
    logic          spk_ready;
    logic          full;
    logic          almost_full;
    logic          w_en;
    logic [IW-1:0] s_index_o;
    logic          ts_done;
    logic [CW-1:0] ev_cnt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int ts_q[$];
    int mon_e;

    // Flow-control sources: directed (af_drv) or a FIFO model with random drain.
    logic cl_mode   = 1'b0;
    logic af_drv    = 1'b0;
    logic af_rand   = 1'b0;
    logic full_rand = 1'b0;
    logic pop_nb    = 1'b0;
    logic bp_edge   = 1'b0;
    int   fifo_cnt  = 0;

    assign full        = cl_mode ? ((fifo_cnt == DEPTH) || full_rand) : 1'b0;
    assign almost_full = cl_mode ? ((fifo_cnt >= DEPTH - 1) || af_rand) : af_drv;

    spike_index_injector #(
        .N_AXON (N),
        .IDX_W  (IW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spk_valid   (spk_valid),
        .spk_ready   (spk_ready),
        .spk_map     (spk_map),
        .full        (full),
        .almost_full (almost_full),
        .w_en        (w_en),
        .s_index_o   (s_index_o),
        .ts_done     (ts_done),
        .ev_cnt      (ev_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_map(input logic [N-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                exp_q.push_back(i);
                c++;
            end
        end
        ts_q.push_back(c);
    endfunction

    // Flag state the DUT saw at the last rising edge.
    always @(posedge clk) bp_edge <= almost_full | full;

    always @(posedge clk) begin
        if (!cl_mode) fifo_cnt <= 0;
        else          fifo_cnt <= fifo_cnt + (w_en ? 1 : 0) - (pop_nb ? 1 : 0);
    end

    always @(negedge clk) begin
        pop_nb    = cl_mode && (fifo_cnt > 0) && ($urandom_range(0, 1) == 1);
        af_rand   = cl_mode && ($urandom_range(0, 7) == 0);
        full_rand = cl_mode && ($urandom_range(0, 15) == 0);
        if (cl_mode && w_en)
            chk("fifo_overflow", ((fifo_cnt == DEPTH) && !pop_nb) ? 1 : 0, 0);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (w_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_w_en: index %0d written, none expected (t=%0t)",
                         s_index_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("index", s_index_o, mon_e);
            end
            chk("issue_under_backpressure", bp_edge, 0);
        end
        if (ts_done) begin
            if (ts_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ts_done: ev_cnt %0d, none expected (t=%0t)",
                         ev_cnt, $time);
            end else begin
                mon_e = ts_q.pop_front();
                chk("ev_cnt", ev_cnt, mon_e);
            end
        end
    end

    // Called at a negedge; returns 1 ns after the accepting rising edge.
    task automatic send(input logic [N-1:0] m);
        int k;
        spk_map   = m;
        spk_valid = 1'b1;
        k = 0;
        while (!spk_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", spk_ready, 1);
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!ts_done && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("ts_done_timeout", ts_done, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;

        // Reset held 3 clocks with a valid bitmap offered.
        rstn      = 1'b0;
        spk_valid = 1'b1;
        spk_map   = '1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_spk_ready", spk_ready, 1);
            chk("rst_w_en", w_en, 0);
        end
        chk("rst_s_index", s_index_o, 0);
        chk("rst_ev_cnt", ev_cnt, 0);
        chk("rst_ts_done", ts_done, 0);
        spk_valid = 1'b0;
        rstn      = 1'b1;
        @(negedge clk);
        chk("rst_no_accept", spk_ready, 1);

        // Bits {3,17,255}: first write registered on the edge after accept
        // (captured by the FIFO on the 2nd edge), then back to back.
        m = '0;
        m[3] = 1'b1; m[17] = 1'b1; m[255] = 1'b1;
        exp_q.push_back(3); exp_q.push_back(17); exp_q.push_back(255);
        ts_q.push_back(3);
        @(negedge clk);
        send(m);
        @(negedge clk); chk("lat_not_early", w_en, 0);
        @(negedge clk); chk("lat_first_w_en", w_en, 1);
        @(negedge clk); chk("burst_w_en_2", w_en, 1);
        @(negedge clk); chk("burst_w_en_3", w_en, 1);
        @(negedge clk); chk("ts_after_last", ts_done, 1);
        chk("no_w_en_at_ts", w_en, 0);
        @(negedge clk); chk("ts_one_cycle", ts_done, 0);
        chk("ready_after_fin", spk_ready, 1);
        chk("ev_cnt_hold", ev_cnt, 3);

        // Empty bitmap.
        ts_q.push_back(0);
        send('0);
        @(negedge clk); chk("empty_ts_early", ts_done, 0);
        @(negedge clk); chk("empty_ts_done", ts_done, 1);
        chk("empty_ev_cnt", ev_cnt, 0);
        @(negedge clk); chk("empty_ready", spk_ready, 1);

        // All 256 bits; almost_full held 10 clocks after the 4th write.
        expect_map('1);
        send('1);
        repeat (5) @(negedge clk);
        chk("af_pre_w_en", w_en, 1);
        chk("af_pre_index", s_index_o, 3);
        af_drv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("af_gap", w_en, 0);
        end
        af_drv = 1'b0;
        @(negedge clk);
        chk("af_resume", w_en, 1);
        chk("af_resume_index", s_index_o, 4);
        wait_done(400);
        chk("full_ev_cnt", ev_cnt, 256);
        @(negedge clk);

        // Reset mid-drain of 0xFF after index 2.
        expect_map(256'hFF);
        send(256'hFF);
        repeat (4) @(negedge clk);
        chk("mid_idx2", s_index_o, 2);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_w_en", w_en, 0);
        chk("mid_rst_idle", spk_ready, 1);
        chk("mid_rst_ev_cnt", ev_cnt, 0);
        exp_q.delete();
        ts_q.delete();
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_w_en", w_en, 0);
        end
        m = '0;
        m[5] = 1'b1;
        exp_q.push_back(5);
        ts_q.push_back(1);
        send(m);
        wait_done(20);
        @(negedge clk);

        // Closed loop against a FIFO model with random drain and flags.
        cl_mode = 1'b1;
        for (int t = 0; t < 30; t++) begin
            for (int w = 0; w < N / 32; w++) begin
                case (t % 3)
                    0:       m[w*32 +: 32] = $urandom();
                    1:       m[w*32 +: 32] = $urandom() & $urandom() & $urandom();
                    default: m[w*32 +: 32] = (w == t % 8) ? $urandom() : 32'h0;
                endcase
            end
            expect_map(m);
            send(m);
            wait_done(3000);
            @(negedge clk);
        end
        cl_mode = 1'b0;
        repeat (3) @(negedge clk);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("ts_q_drained", ts_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spike_index_injector

`default_nettype wire
